// File: rtl/clk_period_meter.sv
// Period / high-time meter for an asynchronous square wave, in clkin cycles.
// Each result is the truncated average of 2^AVG_LOG2 consecutive periods.
module clk_period_meter #(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sigin,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state_reg, state_next;

  logic s1_reg, s2_reg, s3_reg;
  logic rise;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  hcnt_reg, hcnt_next;
  logic [ACC_W-1:0]  pacc_reg, pacc_next;
  logic [ACC_W-1:0]  hacc_reg, hacc_next;
  logic [NPER_W-1:0] nper_reg, nper_next;
  logic [CNT_W-1:0]  period_reg, period_next;
  logic [CNT_W-1:0]  high_reg, high_next;
  logic              valid_reg, valid_next;
  logic              timeout_reg, timeout_next;

  logic [ACC_W-1:0]  psum, hsum;

  assign rise = s2_reg & ~s3_reg;

  // Running sums including the sample that closes on this rise.
  assign psum = pacc_reg + ACC_W'(cnt_reg) + 1'b1;
  assign hsum = hacc_reg + ACC_W'(hcnt_reg);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hcnt_next    = hcnt_reg;
    pacc_next    = pacc_reg;
    hacc_next    = hacc_reg;
    nper_next    = nper_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;

    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        hcnt_next = '0;
        if (rise) begin
          state_next   = MEASURE;
          pacc_next    = '0;
          hacc_next    = '0;
          nper_next    = '0;
          timeout_next = 1'b0;
        end
      end

      MEASURE: begin
        if (rise) begin
          cnt_next  = '0;
          hcnt_next = '0;
          if (nper_reg == NPER_LAST) begin
            period_next = CNT_W'(psum >> AVG_LOG2);
            high_next   = CNT_W'(hsum >> AVG_LOG2);
            valid_next  = 1'b1;
            pacc_next   = '0;
            hacc_next   = '0;
            nper_next   = '0;
          end else begin
            pacc_next = psum;
            hacc_next = hsum;
            nper_next = nper_reg + 1'b1;
          end
        end else if (cnt_reg == CNT_LAST) begin
          // Edge missing for TIMEOUT cycles: drop the partial average.
          state_next   = IDLE;
          timeout_next = 1'b1;
          cnt_next     = '0;
          hcnt_next    = '0;
          pacc_next    = '0;
          hacc_next    = '0;
          nper_next    = '0;
        end else begin
          cnt_next  = cnt_reg + 1'b1;
          hcnt_next = hcnt_reg + CNT_W'(s3_reg);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_reg   <= IDLE;
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      s3_reg      <= 1'b0;
      cnt_reg     <= '0;
      hcnt_reg    <= '0;
      pacc_reg    <= '0;
      hacc_reg    <= '0;
      nper_reg    <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s1_reg      <= sigin;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      cnt_reg     <= cnt_next;
      hcnt_reg    <= hcnt_next;
      pacc_reg    <= pacc_next;
      hacc_reg    <= hacc_next;
      nper_reg    <= nper_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  assign period_out   = period_reg;
  assign high_out     = high_reg;
  assign period_valid = valid_reg;
  assign timeout      = timeout_reg;
  assign busy         = (state_reg == MEASURE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: three instances share sigin/rst and are
// checked against hand-computed periods, high times and result timing.
module tb_clk_period_meter;

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic        sigin = 1'b0;
  logic [23:0] po [3];
  logic [23:0] ho [3];
  logic        pv [3];
  logic        to [3];
  logic        bz [3];

  always #5 clkin = ~clkin;

  // inst 0: AVG 2, TIMEOUT 100; inst 1: AVG 2, TIMEOUT 16; inst 2: AVG 0, TIMEOUT 100
  clk_period_meter #(.CNT_W(24), .AVG_LOG2(2), .TIMEOUT(100)) dut_a (
    .clkin(clkin), .rst(rst), .sigin(sigin), .period_out(po[0]), .high_out(ho[0]),
    .period_valid(pv[0]), .timeout(to[0]), .busy(bz[0]));
  clk_period_meter #(.CNT_W(24), .AVG_LOG2(2), .TIMEOUT(16)) dut_c (
    .clkin(clkin), .rst(rst), .sigin(sigin), .period_out(po[1]), .high_out(ho[1]),
    .period_valid(pv[1]), .timeout(to[1]), .busy(bz[1]));
  clk_period_meter #(.CNT_W(24), .AVG_LOG2(0), .TIMEOUT(100)) dut_m (
    .clkin(clkin), .rst(rst), .sigin(sigin), .period_out(po[2]), .high_out(ho[2]),
    .period_valid(pv[2]), .timeout(to[2]), .busy(bz[2]));

  typedef struct {
    int inst;
    int e;
    int p;
    int h;
  } ev_t;

  typedef struct {
    int inst;
    int hi0, lo0, hi1, lo1;
    int nper;
    int exp_p, exp_h, exp_nv;
  } vec_t;

  int   edge_n = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   alog [3] = '{2, 2, 0};
  int   tocnt [3] = '{0, 0, 0};
  ev_t  vq [$];
  int   rises [$];
  vec_t vecs [6];

  always @(posedge clkin) edge_n <= edge_n + 1;

  always @(negedge clkin) begin : mon
    ev_t ev;
    for (int i = 0; i < 3; i++) begin
      if (pv[i]) begin
        ev.inst = i;
        ev.e    = edge_n;
        ev.p    = int'(po[i]);
        ev.h    = int'(ho[i]);
        vq.push_back(ev);
        $display("valid inst%0d cycle %0d period %0d high %0d", i, edge_n, ev.p, ev.h);
      end
      if (to[i]) tocnt[i]++;
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sigin = 1'b0;
    rst   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rises.delete();
  endtask

  // sigin rises just after edge k, so the meter's rise cycle follows edge k+2
  task automatic pulse(input int hi, input int lo);
    sigin = 1'b1;
    rises.push_back(edge_n + 2);
    repeat (hi) tick();
    sigin = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wave(input int hi0, input int lo0, input int hi1, input int lo1, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 1) pulse(hi1, lo1);
      else            pulse(hi0, lo0);
    end
  endtask

  // Result j lands one cycle after the rise that closes its (j+1)*2^A-th period.
  task automatic check_valids(input string tag, input int inst, input int vbase,
                              input int exp_n, input int exp_p, input int exp_h);
    int nv;
    int idx;
    nv = 0;
    for (int j = vbase; j < vq.size(); j++) begin
      if (vq[j].inst == inst) begin
        idx = (nv + 1) << alog[inst];
        check($sformatf("%s_period%0d", tag, nv), vq[j].p, exp_p);
        check($sformatf("%s_high%0d", tag, nv), vq[j].h, exp_h);
        check($sformatf("%s_time%0d", tag, nv), vq[j].e,
              (idx < rises.size()) ? rises[idx] + 1 : -1);
        nv++;
      end
    end
    check({tag, "_count"}, nv, exp_n);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int vbase;
    int tbase;
    int rl;
    int r;

    vecs[0] = '{0, 8, 8, 8, 8,  9, 16, 8, 2};  // divide-by-16
    vecs[1] = '{0, 7, 8, 7, 10, 9, 16, 7, 2};  // 15/17 alternating
    vecs[2] = '{0, 4, 4, 4, 4,  9, 8,  4, 2};
    vecs[3] = '{1, 8, 8, 8, 8,  5, 16, 8, 1};  // edge on cnt == TIMEOUT-1
    vecs[4] = '{2, 2, 2, 2, 2,  9, 4,  2, 8};  // minimum period
    vecs[5] = '{2, 3, 5, 3, 5,  5, 8,  3, 4};

    // Reset with sigin toggling
    tick();
    for (int c = 0; c < 3; c++) begin
      sigin = ~sigin;
      tick();
      for (int i = 0; i < 3; i++)
        check($sformatf("reset_inst%0d_c%0d", i, c), {po[i], ho[i], pv[i], to[i], bz[i]}, 0);
    end

    foreach (vecs[v]) begin
      do_reset();
      vbase = vq.size();
      tbase = tocnt[vecs[v].inst];
      wave(vecs[v].hi0, vecs[v].lo0, vecs[v].hi1, vecs[v].lo1, vecs[v].nper);
      check_valids($sformatf("vec%0d", v), vecs[v].inst, vbase,
                   vecs[v].exp_nv, vecs[v].exp_p, vecs[v].exp_h);
      check($sformatf("vec%0d_no_timeout", v), tocnt[vecs[v].inst] - tbase, 0);
    end

    // Periods 16,16,16,17 with highs 8,8,8,9: both sums truncate
    do_reset();
    vbase = vq.size();
    pulse(8, 8); pulse(8, 8); pulse(8, 8); pulse(9, 8); pulse(8, 8);
    check_valids("trunc", 0, vbase, 1, 16, 8);

    // Timeout and recovery on inst 0 (TIMEOUT 100)
    do_reset();
    vbase = vq.size();
    wave(8, 8, 8, 8, 11);
    rl = rises[10];
    for (int i = 0; i < 200 && edge_n < rl + 100; i++) tick();
    check("to_before", to[0], 0);
    check("busy_before", bz[0], 1);
    tick();
    check("to_at_101", to[0], 1);
    check("busy_at_101", bz[0], 0);
    check("to_period_hold", po[0], 16);
    check("to_high_hold", ho[0], 8);
    repeat (30) tick();
    check("to_sticky", to[0], 1);
    check_valids("pre_to", 0, vbase, 2, 16, 8);

    vbase = vq.size();
    rises.delete();
    sigin = 1'b1;
    r = edge_n + 2;
    rises.push_back(r);
    tick(); tick();
    check("resume_to_in_rise", to[0], 1);
    tick();
    check("resume_to_clear", to[0], 0);
    check("resume_busy", bz[0], 1);
    repeat (5) tick();
    sigin = 1'b0;
    repeat (8) tick();
    wave(8, 8, 8, 8, 4);
    check_valids("resume", 0, vbase, 1, 16, 8);

    // Period 17 against TIMEOUT 16: one timeout cycle per gap, never a result
    do_reset();
    vbase = vq.size();
    tbase = tocnt[1];
    wave(8, 9, 8, 9, 6);
    check_valids("coll17", 1, vbase, 0, 0, 0);
    check("coll17_timeout_cycles", tocnt[1] - tbase, 5);

    // Reset in the middle of an averaging window
    do_reset();
    vbase = vq.size();
    wave(8, 8, 8, 8, 11);
    check("mid_pre_period", po[0], 16);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", {po[0], ho[0], pv[0], to[0], bz[0]}, 0);
    rst = 1'b0;
    tick();
    rises.delete();
    vbase = vq.size();
    wave(8, 8, 8, 8, 5);
    check_valids("mid_after", 0, vbase, 1, 16, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of an asynchronous square wave (e.g. a divided clock or an external test signal) in cycles of the system clock. Results are averaged over 2^AVG_LOG2 periods. It is the measurement-side counterpart of the team's clock dividers: it recovers the division ratio that a divider produced. It sits between an external input pin or divided-clock net and the register bank / display logic, which read `period_out` and `high_out` on `period_valid`.

## Interface
- `CNT_W`, 24: width of period/high counters and outputs.
- `AVG_LOG2`, 2: log2 of the number of periods averaged per result (0 = no averaging).
- `TIMEOUT`, 1000000: maximum cycles between rising edges before timeout. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- `clkin` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sigin` in 1: measured signal, asynchronous to `clkin`.
- `period_out` out CNT_W: averaged period in `clkin` cycles.
- `high_out` out CNT_W: averaged high time in `clkin` cycles.
- `period_valid` out 1: one-cycle pulse when `period_out`/`high_out` update.
- `timeout` out 1: no rising edge seen within TIMEOUT cycles. Sticky.
- `busy` out 1: high in MEASURE state.

## Operation
**Input conditioning**
- Three flops `s1→s2→s3` on `sigin`, all reset to 0.
- `rise = s2 & ~s3` (combinational).

**Counters**
- `cnt`: set to 0 on a `rise` cycle, otherwise +1.
- `hcnt`: set to 0 on `rise`, otherwise `hcnt + s3`.
- One period sample = `cnt+1` cycles. One high sample = `hcnt`.

**Accumulators**
- `pacc` and `hacc`, each CNT_W+AVG_LOG2 bits.
- `nper` counts periods, 0..2^AVG_LOG2−1.

**FSM: IDLE, MEASURE**
- **IDLE:** counters are held at 0. On `rise` → MEASURE; clear `pacc`, `hacc`, `nper`. The first edge only starts timing and produces no sample.
- **MEASURE, `rise` cycle:**
  - Add the samples: `pacc += cnt+1`, `hacc += hcnt`.
  - If `nper == 2^AVG_LOG2−1`:
    - Next cycle: `period_out = (pacc + cnt+1) >> AVG_LOG2` and `high_out = (hacc + hcnt) >> AVG_LOG2` (truncating).
    - Pulse `period_valid`.
    - Clear `pacc`, `hacc`, `nper`.
  - Otherwise `nper += 1`.
  - Stay in MEASURE.
- **MEASURE, timeout:** if `cnt == TIMEOUT−1` and no `rise` in that cycle → set `timeout`, go to IDLE, discard the partial accumulation. `period_out`/`high_out` hold their last values.

**Timeout flag**
- Cleared on the next `rise`, which is the cycle IDLE→MEASURE.

**Boundary rules**
- `rise` in the same cycle as `cnt == TIMEOUT−1`: the edge wins. The sample is TIMEOUT cycles and no timeout is raised.
- Accumulators cannot overflow: a sample is ≤ TIMEOUT < 2^CNT_W.
- Minimum measurable period is 2 cycles high + 2 cycles low. Shorter or glitch pulses may be missed; no error is flagged.
- `rst` at any time: state IDLE. All flops, accumulators and outputs go to 0 on the next edge, and partial data is discarded.

## Timing
- Reset values: `period_out`=0, `high_out`=0, `period_valid`=0, `timeout`=0, `busy`=0.
- `sigin` rising edge to `rise`: 2–3 `clkin` cycles, depending on sampling phase.
- `rise` to `period_valid`:
  - 1 cycle; outputs and `valid` are registered together.
  - `period_valid` is never high for two consecutive cycles. The minimum spacing is 4·2^AVG_LOG2 cycles.
- First result:
  - 2^AVG_LOG2 full periods after the first detected edge following reset or timeout.
  - Nominal edge-to-edge latency of the first result: 2^AVG_LOG2·P + 1 cycles after the first `rise`.
- `busy`:
  - Rises the cycle after the first `rise`.
  - Falls the cycle after timeout or `rst`.
- `timeout`:
  - Asserts the cycle after `cnt == TIMEOUT−1`, i.e. TIMEOUT cycles after the last `rise` (+1 register).

## Test plan
- **Reset:** assert `rst` for 3 cycles with `sigin` toggling. Required: all outputs 0, `busy`=0, no `period_valid` while `rst` is high.
- **Divide-by-16 signal:**
  - Stimulus: `sigin` toggles every 8 `clkin` cycles; AVG_LOG2=2, CNT_W=24.
  - Required: first `period_valid` exactly 65 cycles after the first `rise`, with `period_out`=16 and `high_out`=8.
  - Every subsequent `valid` comes 64 cycles apart with the same values.
- **Averaging/truncation:**
  - Periods alternating 15/17 with high time 7 → `period_out`=16, `high_out`=7.
  - Periods 16,16,16,17 → `period_out`=16 (65>>2).
- **Timeout and recovery:**
  - Stimulus: TIMEOUT=100; `sigin` held low after an active period.
  - Required: `timeout`=1 and `busy`=0, 101 cycles after the last `rise`. `period_out` is unchanged and no `valid` pulses.
  - Then resume the divide-by-16 signal → `timeout` clears on the first `rise`, and `valid` follows 4 periods later with value 16.
- **Edge/timeout collision:**
  - Stimulus: TIMEOUT=16 with a period-16 signal.
  - Required: no timeout, `period_out`=16.
  - With a period-17 signal: timeout asserted and no `valid`.
- **Reset mid-measurement:**
  - Stimulus: `rst` for 1 cycle after 2 periods of a divide-by-16 signal.
  - Required: outputs return to 0, and the next `valid` appears only after a fresh first edge plus 4 full periods, with `period_out`=16.
- **Minimum period:** `sigin` period 4 (2 high/2 low), AVG_LOG2=0 → `period_valid` every 4 cycles, with `period_out`=4 and `high_out`=2.
